// File: rtl/fixed_point_mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle signed fixed-point multiply sequencer.
package fixed_point_mul_sequencer_pkg;

  typedef enum logic [1:0] {
    MsIdle = 2'd0,
    MsMul  = 2'd1,
    MsSign = 2'd2,
    MsDone = 2'd3
  } ms_state_e;

  localparam int unsigned NumPartials = 4;

  // Fixed-point unit operation code that routes through this sequencer.
  localparam logic [3:0] FpuMul = 4'd2;

endpackage

// File: rtl/fixed_point_mul_sequencer_if.sv
// Start/busy/done handshake bundle between the FPU MUL path and the sequencer.
interface fixed_point_mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output start, operand_1, operand_2,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, operand_1, operand_2,
    output busy, done, result, overflow
  );

endinterface

// File: rtl/fixed_point_mul_sequencer_mul_half.sv
// Combinational (WIDTH/2)x(WIDTH/2) unsigned multiplier with a WIDTH-bit product.
module fixed_point_mul_sequencer_mul_half #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH/2-1:0] a,
  input  logic [WIDTH/2-1:0] b,
  output logic [WIDTH-1:0]   p
);

  localparam int unsigned Half = WIDTH / 2;

  // Zero-extend both factors so the product is computed at full width.
  assign p = {{Half{1'b0}}, a} * {{Half{1'b0}}, b};

endmodule

// File: rtl/fixed_point_mul_sequencer.sv
// Signed Q-format multiply built from four half-width unsigned partial products,
// followed by sign correction, truncating slice and overflow detection.
module fixed_point_mul_sequencer
  import fixed_point_mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FBITS = 10
) (
  input logic                        clk,
  input logic                        reset,
  fixed_point_mul_sequencer_if.slave bus
);

  localparam int unsigned Half = WIDTH / 2;
  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned TopW = WIDTH - FBITS + 1;

  ms_state_e         state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              neg_q;
  logic [AccW-1:0]   acc_q;
  logic [1:0]        cnt_q;
  logic              busy_q, done_q, overflow_q;
  logic [WIDTH-1:0]  result_q;

  logic [WIDTH-1:0]  abs_1, abs_2;
  logic [Half-1:0]   mul_a, mul_b;
  logic [WIDTH-1:0]  pp;
  logic [AccW-1:0]   pp_shifted;
  logic [AccW-1:0]   full;
  logic [TopW-1:0]   full_top;

  // The most negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
  assign abs_1 = bus.operand_1[WIDTH-1] ? -bus.operand_1 : bus.operand_1;
  assign abs_2 = bus.operand_2[WIDTH-1] ? -bus.operand_2 : bus.operand_2;

  always_comb begin
    mul_a      = a_q[Half-1:0];
    mul_b      = b_q[Half-1:0];
    pp_shifted = {{WIDTH{1'b0}}, pp};
    case (cnt_q)
      2'd0: begin
        mul_a      = a_q[Half-1:0];
        mul_b      = b_q[Half-1:0];
        pp_shifted = {{WIDTH{1'b0}}, pp};
      end
      2'd1: begin
        mul_a      = a_q[Half-1:0];
        mul_b      = b_q[WIDTH-1:Half];
        pp_shifted = {{Half{1'b0}}, pp, {Half{1'b0}}};
      end
      2'd2: begin
        mul_a      = a_q[WIDTH-1:Half];
        mul_b      = b_q[Half-1:0];
        pp_shifted = {{Half{1'b0}}, pp, {Half{1'b0}}};
      end
      default: begin
        mul_a      = a_q[WIDTH-1:Half];
        mul_b      = b_q[WIDTH-1:Half];
        pp_shifted = {pp, {WIDTH{1'b0}}};
      end
    endcase
  end

  fixed_point_mul_sequencer_mul_half #(
    .WIDTH (WIDTH)
  ) u_mul_half (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  assign full     = neg_q ? -acc_q : acc_q;
  assign full_top = full[AccW-1:WIDTH+FBITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MsIdle;
      a_q        <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        MsIdle: begin
          if (bus.start) begin
            a_q     <= abs_1;
            b_q     <= abs_2;
            neg_q   <= bus.operand_1[WIDTH-1] ^ bus.operand_2[WIDTH-1];
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MsMul;
          end
        end
        MsMul: begin
          acc_q <= acc_q + pp_shifted;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'(NumPartials - 1)) begin
            state_q <= MsSign;
          end
        end
        MsSign: begin
          result_q   <= full[WIDTH+FBITS-1:FBITS];
          // Representable only when the discarded high bits are a pure sign extension.
          overflow_q <= !((&full_top) || !(|full_top));
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= MsDone;
        end
        MsDone: begin
          done_q  <= 1'b0;
          state_q <= MsIdle;
        end
        default: state_q <= MsIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fixed_point_mul_sequencer.sv
// Directed self-checking bench for fixed_point_mul_sequencer (WIDTH=32, FBITS=10).
module tb_fixed_point_mul_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fixed_point_mul_sequencer_if #(.WIDTH(32)) bus ();

  fixed_point_mul_sequencer #(
    .WIDTH (32),
    .FBITS (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  // Counts edges until done, then checks latency, result, overflow and the pulse width.
  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [31:0] exp_res, input logic exp_ovf);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (n < exp_lat) check_eq({tag, "_busy_mid"}, 64'(bus.busy), 64'd1);
    end while (!bus.done && n < 12);
    check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check_eq({tag, "_result"}, 64'(bus.result), 64'(exp_res));
    check_eq({tag, "_overflow"}, 64'(bus.overflow), 64'(exp_ovf));
    check_eq({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    tick();
    check_eq({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int first_done;
    int second_done;
    logic [31:0] first_res;
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_outputs", {bus.busy, bus.done, bus.overflow, bus.result}, 64'd0);
    end

    start_op(32'h0000_0600, 32'h0000_0800);
    check_eq("pos_busy_e0", 64'(bus.busy), 64'd1);
    wait_done("pos", 5, 32'h0000_0C00, 1'b0);

    start_op(32'hFFFF_FA00, 32'h0000_0800);
    wait_done("neg", 5, 32'hFFFF_F400, 1'b0);

    start_op(32'hFFFF_FFFF, 32'h0000_0001);
    wait_done("floor_neg", 5, 32'hFFFF_FFFF, 1'b0);

    start_op(32'h0000_0001, 32'h0000_0001);
    wait_done("floor_pos", 5, 32'h0000_0000, 1'b0);

    start_op(32'h8000_0000, 32'h0000_0400);
    wait_done("most_neg", 5, 32'h8000_0000, 1'b0);

    start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done("max_sq", 5, 32'hFFC0_0000, 1'b1);

    start_op(32'h0000_0000, 32'h7FFF_FFFF);
    wait_done("zero", 5, 32'h0000_0000, 1'b0);

    // Restart pulse at E2 with new operands must be ignored.
    start_op(32'h0000_0600, 32'h0000_0800);
    tick();
    bus.operand_1 = 32'h7FFF_FFFF;
    bus.operand_2 = 32'h7FFF_FFFF;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    wait_done("abuse", 3, 32'h0000_0C00, 1'b0);

    // Held start: two back-to-back operations seven cycles apart.
    bus.operand_1 = 32'hFFFF_FA00;
    bus.operand_2 = 32'h0000_0800;
    bus.start     = 1'b1;
    first_done    = -1;
    second_done   = -1;
    first_res     = '0;
    for (int c = 0; c < 30 && second_done < 0; c++) begin
      tick();
      if (bus.done) begin
        if (first_done < 0) begin
          first_done = c;
          first_res  = bus.result;
        end else begin
          second_done = c;
        end
      end
    end
    bus.start = 1'b0;
    check_eq("b2b_seen", 64'(second_done >= 0), 64'd1);
    check_eq("b2b_spacing", 64'(second_done - first_done), 64'd7);
    check_eq("b2b_first", 64'(first_res), 64'hFFFF_F400);
    check_eq("b2b_second", 64'(bus.result), 64'hFFFF_F400);
    tick();
    tick();

    // Reset at E3 aborts the operation; result was nonzero beforehand.
    start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_outputs", {bus.busy, bus.done, bus.overflow, bus.result}, 64'd0);
    start_op(32'hFFFF_FA00, 32'h0000_0800);
    wait_done("after_abort", 5, 32'hFFFF_F400, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
